// File: rtl/multi_sync_pulser.sv
`default_nettype none
// ============================================================================
// Module   : multi_sync_pulser
// Purpose  : Multi-channel pulse sequencer. Each channel synchronises one
//            asynchronous sync input, detects a selectable edge and emits a
//            delayed, programmable pulse train. It supports one-shot arming
//            and keeps a saturating count of triggers that were rejected
//            because the channel was busy.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports (channel i uses slice [i*W +: W] of each packed vector):
//   CLK, RST_N    clock, synchronous active-low reset
//   SYNC_IN       asynchronous sync inputs
//   SW_START      software trigger (one-cycle pulse)
//   ARM           re-arm pulse for one-shot channels
//   CLEAR         clears MISSED counter
//   CFG_EN        channel enable
//   CFG_EDGE      00 rising, 01 falling, 10 both, 11 none
//   CFG_ONESHOT   disarm after each completed train
//   CFG_DELAY     cycles from trigger to first pulse
//   CFG_WIDTH     pulse high cycles (0 treated as 1)
//   CFG_GAP       low cycles between pulses (0 treated as 1)
//   CFG_REPEAT    pulses per train, 0 = continuous
//   STROBE        detected-edge strobe (decoded, not registered)
//   PULSE         registered pulse output
//   BUSY          channel not idle
//   DONE          one-cycle strobe at train completion
//   ARMED         channel accepts triggers
//   MISSED        saturating count of triggers rejected while busy
// ============================================================================
module multi_sync_pulser #(
  parameter int CHANNELS    = 2,
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [CHANNELS-1:0]           SYNC_IN,
  input  logic [CHANNELS-1:0]           SW_START,
  input  logic [CHANNELS-1:0]           ARM,
  input  logic [CHANNELS-1:0]           CLEAR,
  input  logic [CHANNELS-1:0]           CFG_EN,
  input  logic [2*CHANNELS-1:0]         CFG_EDGE,
  input  logic [CHANNELS-1:0]           CFG_ONESHOT,
  input  logic [CNT_WIDTH*CHANNELS-1:0] CFG_DELAY,
  input  logic [CNT_WIDTH*CHANNELS-1:0] CFG_WIDTH,
  input  logic [CNT_WIDTH*CHANNELS-1:0] CFG_GAP,
  input  logic [8*CHANNELS-1:0]         CFG_REPEAT,
  output logic [CHANNELS-1:0]           STROBE,
  output logic [CHANNELS-1:0]           PULSE,
  output logic [CHANNELS-1:0]           BUSY,
  output logic [CHANNELS-1:0]           DONE,
  output logic [CHANNELS-1:0]           ARMED,
  output logic [8*CHANNELS-1:0]         MISSED
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_HIGH  = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   sync_last;
    logic                   strobe;
    logic [1:0]             edge_sel;
    logic [CNT_WIDTH-1:0]   cfg_delay;
    logic [CNT_WIDTH-1:0]   cfg_width;
    logic [CNT_WIDTH-1:0]   cfg_gap;
    logic [7:0]             cfg_repeat;
    state_t                 state_q;
    state_t                 state_d;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic [7:0]             pcnt_q;
    logic [7:0]             pcnt_d;
    logic [7:0]             pcnt_inc;
    logic [CNT_WIDTH-1:0]   wid_q;
    logic [CNT_WIDTH-1:0]   gap_q;
    logic [7:0]             rep_q;
    logic                   load;
    logic                   done_d;
    logic                   armed_q;
    logic                   pulse_q;
    logic                   busy_q;
    logic                   done_q;
    logic [7:0]             missed_q;
    logic                   trig;
    logic                   miss;

    // Width and gap of zero behave as one cycle.
    assign edge_sel   = CFG_EDGE[2*i +: 2];
    assign cfg_delay  = CFG_DELAY[i*CNT_WIDTH +: CNT_WIDTH];
    assign cfg_width  = (CFG_WIDTH[i*CNT_WIDTH +: CNT_WIDTH] == '0) ? CNT_ONE
                        : CFG_WIDTH[i*CNT_WIDTH +: CNT_WIDTH];
    assign cfg_gap    = (CFG_GAP[i*CNT_WIDTH +: CNT_WIDTH] == '0) ? CNT_ONE
                        : CFG_GAP[i*CNT_WIDTH +: CNT_WIDTH];
    assign cfg_repeat = CFG_REPEAT[8*i +: 8];

    // Synchroniser chain plus one history flop for edge detection.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        sync_q <= '0;
        hist_q <= 1'b0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], SYNC_IN[i]};
        hist_q <= sync_q[SYNC_STAGES-1];
      end
    end

    assign sync_last = sync_q[SYNC_STAGES-1];

    always_comb begin
      strobe = 1'b0;
      case (edge_sel)
        2'b00:   strobe = sync_last & ~hist_q;
        2'b01:   strobe = ~sync_last & hist_q;
        2'b10:   strobe = sync_last ^ hist_q;
        default: strobe = 1'b0;
      endcase
    end

    // A simultaneous strobe and software start merge into one trigger.
    assign trig     = (strobe | SW_START[i]) & CFG_EN[i] & armed_q;
    assign miss     = trig & (state_q != ST_IDLE);
    assign pcnt_inc = pcnt_q + 8'd1;

    // Next-state logic. Counters run down to zero, so each phase lasts
    // (loaded value + 1) cycles; the delay value itself lives only in cnt_q
    // because it is consumed at trigger time.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pcnt_d  = pcnt_q;
      load    = 1'b0;
      done_d  = 1'b0;
      if (!CFG_EN[i]) begin
        state_d = ST_IDLE;
        pcnt_d  = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (trig) begin
              load   = 1'b1;
              pcnt_d = '0;
              if (cfg_delay == '0) begin
                state_d = ST_HIGH;
                cnt_d   = cfg_width - CNT_ONE;
              end else begin
                state_d = ST_DELAY;
                cnt_d   = cfg_delay - CNT_ONE;
              end
            end
          end
          ST_DELAY: begin
            if (cnt_q == '0) begin
              state_d = ST_HIGH;
              cnt_d   = wid_q - CNT_ONE;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          ST_HIGH: begin
            if (cnt_q == '0) begin
              pcnt_d = pcnt_inc;
              if ((rep_q != '0) && (pcnt_inc == rep_q)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_GAP;
                cnt_d   = gap_q - CNT_ONE;
              end
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          ST_GAP: begin
            if (cnt_q == '0) begin
              state_d = ST_HIGH;
              cnt_d   = wid_q - CNT_ONE;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    // State, shadow registers and registered outputs (derived from the next
    // state so they line up with the state register).
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        state_q <= ST_IDLE;
        cnt_q   <= '0;
        pcnt_q  <= '0;
        wid_q   <= CNT_ONE;
        gap_q   <= CNT_ONE;
        rep_q   <= '0;
        pulse_q <= 1'b0;
        busy_q  <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        pcnt_q  <= pcnt_d;
        pulse_q <= (state_d == ST_HIGH);
        busy_q  <= (state_d != ST_IDLE);
        done_q  <= done_d;
        if (load) begin
          wid_q <= cfg_width;
          gap_q <= cfg_gap;
          rep_q <= cfg_repeat;
        end
      end
    end

    // Arming and missed-trigger bookkeeping; CLEAR beats a same-cycle miss.
    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        armed_q  <= 1'b1;
        missed_q <= '0;
      end else begin
        if (!CFG_ONESHOT[i] || ARM[i]) begin
          armed_q <= 1'b1;
        end else if (done_d) begin
          armed_q <= 1'b0;
        end
        if (CLEAR[i]) begin
          missed_q <= '0;
        end else if (miss && (missed_q != 8'hFF)) begin
          missed_q <= missed_q + 8'd1;
        end
      end
    end

    assign STROBE[i]       = strobe;
    assign PULSE[i]        = pulse_q;
    assign BUSY[i]         = busy_q;
    assign DONE[i]         = done_q;
    assign ARMED[i]        = armed_q;
    assign MISSED[8*i +: 8] = missed_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_sync_pulser.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_sync_pulser
// Purpose  : Self-checking bench for multi_sync_pulser. Stimulus pushes the
//            expected PULSE rise/fall and DONE events (sample index, channel,
//            kind) into a scoreboard queue; a monitor observes the outputs on
//            every falling clock edge and compares each event it sees.
//            Sample index N means "value sampled at rising edge N".
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_sync_pulser;

  localparam int CH = 2;
  localparam int CW = 16;
  localparam int K_RISE = 0;
  localparam int K_FALL = 1;
  localparam int K_DONE = 2;

  logic            clk;
  logic            rst_n;
  logic [CH-1:0]   sync_in, sw_start, arm, clear, cfg_en, cfg_oneshot;
  logic [2*CH-1:0] cfg_edge;
  logic [CW*CH-1:0] cfg_delay, cfg_width, cfg_gap;
  logic [8*CH-1:0] cfg_repeat;
  logic [CH-1:0]   strobe, pulse, busy, done, armed;
  logic [8*CH-1:0] missed;

  multi_sync_pulser #(.CHANNELS(CH), .CNT_WIDTH(CW), .SYNC_STAGES(2)) dut (
    .CLK(clk), .RST_N(rst_n), .SYNC_IN(sync_in), .SW_START(sw_start),
    .ARM(arm), .CLEAR(clear), .CFG_EN(cfg_en), .CFG_EDGE(cfg_edge),
    .CFG_ONESHOT(cfg_oneshot), .CFG_DELAY(cfg_delay), .CFG_WIDTH(cfg_width),
    .CFG_GAP(cfg_gap), .CFG_REPEAT(cfg_repeat), .STROBE(strobe),
    .PULSE(pulse), .BUSY(busy), .DONE(done), .ARMED(armed), .MISSED(missed)
  );

  typedef struct {
    int idx;
    int ch;
    int kind;
  } ev_t;

  ev_t sb_q[$];
  int  cyc = 0;
  int  checks = 0;
  int  failures = 0;
  logic [CH-1:0] prev_pulse = '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int idx, input int ch, input int kind);
    ev_t e;
    e.idx = idx; e.ch = ch; e.kind = kind;
    sb_q.push_back(e);
  endtask

  task automatic observe(input int idx, input int ch, input int kind);
    ev_t e;
    checks++;
    if (sb_q.size() == 0) begin
      failures++;
      $display("FAIL sb_unexpected: got event idx=%0d ch=%0d kind=%0d, expected none",
               idx, ch, kind);
    end else begin
      e = sb_q.pop_front();
      if (e.idx != idx || e.ch != ch || e.kind != kind) begin
        failures++;
        $display("FAIL sb_event: got idx=%0d ch=%0d kind=%0d, expected idx=%0d ch=%0d kind=%0d",
                 idx, ch, kind, e.idx, e.ch, e.kind);
      end
    end
  endtask

  // Monitor: events sampled at this falling edge belong to index cyc+1.
  always @(negedge clk) begin
    for (int c = 0; c < CH; c++) begin
      if (pulse[c] === 1'b1 && prev_pulse[c] === 1'b0) observe(cyc + 1, c, K_RISE);
      if (pulse[c] === 1'b0 && prev_pulse[c] === 1'b1) observe(cyc + 1, c, K_FALL);
      if (done[c] === 1'b1) observe(cyc + 1, c, K_DONE);
    end
    prev_pulse = pulse;
  end

  // Bounded wait until the falling edge that shows sample index k.
  task automatic wait_idx(input int k);
    while (cyc + 1 < k) @(negedge clk);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_pulse"}, int'(pulse), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_armed"}, int'(armed), 3);
    chk({tag, "_missed"}, int'(missed), 0);
    chk({tag, "_strobe"}, int'(strobe), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t, t2, n;
    rst_n = 1'b0; sync_in = '0; sw_start = '0; arm = '0; clear = '0;
    cfg_en = '0; cfg_oneshot = '0; cfg_edge = '1; cfg_delay = '0;
    cfg_width = '0; cfg_gap = '0; cfg_repeat = '0;
    repeat (3) @(negedge clk);
    chk_reset_values("reset");
    rst_n = 1'b1;

    // Test 1: rising edge, DELAY=3 WIDTH=2 GAP=4 REPEAT=3 on ch0.
    cfg_en = 2'b01; cfg_edge = 4'b1100;
    cfg_delay[0 +: CW] = 16'd3; cfg_width[0 +: CW] = 16'd2;
    cfg_gap[0 +: CW] = 16'd4; cfg_repeat[0 +: 8] = 8'd3;
    @(negedge clk);
    n = cyc; sync_in[0] = 1'b1; t = n + 3;
    push(t + 4, 0, K_RISE);  push(t + 6, 0, K_FALL);
    push(t + 10, 0, K_RISE); push(t + 12, 0, K_FALL);
    push(t + 16, 0, K_RISE); push(t + 18, 0, K_FALL); push(t + 18, 0, K_DONE);
    @(negedge clk); chk("t1_strobe_early", int'(strobe[0]), 0);
    @(negedge clk); chk("t1_strobe", int'(strobe[0]), 1);
    @(negedge clk); chk("t1_strobe_once", int'(strobe[0]), 0);
    chk("t1_busy", int'(busy[0]), 1);
    wait_idx(t + 18); chk("t1_busy_at_done", int'(busy[0]), 0);
    wait_idx(t + 20);
    chk("t1_missed", int'(missed[7:0]), 0);
    chk("t1_sb_drained", sb_q.size(), 0);

    // Test 2: both edges, 40-cycle SYNC_IN pulse, DELAY=0 WIDTH=1 REPEAT=1.
    sync_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    cfg_edge[1:0] = 2'b10; cfg_delay[0 +: CW] = 16'd0;
    cfg_width[0 +: CW] = 16'd1; cfg_repeat[0 +: 8] = 8'd1;
    @(negedge clk);
    sync_in[0] = 1'b1; t = cyc + 3;
    push(t + 1, 0, K_RISE); push(t + 2, 0, K_FALL); push(t + 2, 0, K_DONE);
    repeat (40) @(negedge clk);
    sync_in[0] = 1'b0; t2 = cyc + 3;
    push(t2 + 1, 0, K_RISE); push(t2 + 2, 0, K_FALL); push(t2 + 2, 0, K_DONE);
    wait_idx(t2 + 4);
    chk("t2_missed", int'(missed[7:0]), 0);
    chk("t2_sb_drained", sb_q.size(), 0);

    // Test 3: long pulse, 300 retriggers, saturation, CLEAR vs miss, disable.
    cfg_edge[1:0] = 2'b11; cfg_width[0 +: CW] = 16'd1000;
    @(negedge clk);
    sw_start[0] = 1'b1; t = cyc + 1; push(t + 1, 0, K_RISE);
    @(negedge clk); sw_start[0] = 1'b0;
    @(negedge clk); chk("t3_busy", int'(busy[0]), 1);
    for (int i = 0; i < 300; i++) begin
      sw_start[0] = 1'b1;
      @(negedge clk);
      sw_start[0] = 1'b0;
      if (i == 9)   chk("t3_missed_10", int'(missed[7:0]), 10);
      if (i == 254) chk("t3_missed_255", int'(missed[7:0]), 255);
      if (i == 299) chk("t3_missed_sat", int'(missed[7:0]), 255);
      @(negedge clk);
    end
    clear[0] = 1'b1; sw_start[0] = 1'b1;
    @(negedge clk);
    chk("t3_clear_wins", int'(missed[7:0]), 0);
    clear[0] = 1'b0; sw_start[0] = 1'b0;
    @(negedge clk); sw_start[0] = 1'b1;
    @(negedge clk); sw_start[0] = 1'b0;
    chk("t3_missed_after_clear", int'(missed[7:0]), 1);
    cfg_en[0] = 1'b0; push(cyc + 2, 0, K_FALL);
    @(negedge clk);
    chk("t3_dis_pulse", int'(pulse[0]), 0);
    chk("t3_dis_busy", int'(busy[0]), 0);
    cfg_en[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("t3_sb_drained", sb_q.size(), 0);

    // Test 4: one-shot, disarmed edge ignored, ARM re-enables.
    clear[0] = 1'b1; @(negedge clk); clear[0] = 1'b0;
    cfg_oneshot[0] = 1'b1; cfg_edge[1:0] = 2'b00; cfg_delay[0 +: CW] = 16'd1;
    cfg_width[0 +: CW] = 16'd2; cfg_gap[0 +: CW] = 16'd1; cfg_repeat[0 +: 8] = 8'd1;
    @(negedge clk);
    sync_in[0] = 1'b1; t = cyc + 3;
    push(t + 2, 0, K_RISE); push(t + 4, 0, K_FALL); push(t + 4, 0, K_DONE);
    wait_idx(t + 4); chk("t4_armed_cleared", int'(armed[0]), 0);
    wait_idx(t + 5); chk("t4_armed_stays", int'(armed[0]), 0);
    sync_in[0] = 1'b0; repeat (3) @(negedge clk);
    sync_in[0] = 1'b1; repeat (10) @(negedge clk);
    chk("t4_disarmed_missed", int'(missed[7:0]), 0);
    chk("t4_disarmed_busy", int'(busy[0]), 0);
    arm[0] = 1'b1; @(negedge clk); arm[0] = 1'b0;
    chk("t4_rearmed", int'(armed[0]), 1);
    sync_in[0] = 1'b0; repeat (3) @(negedge clk);
    sync_in[0] = 1'b1; t = cyc + 3;
    push(t + 2, 0, K_RISE); push(t + 4, 0, K_FALL); push(t + 4, 0, K_DONE);
    wait_idx(t + 5);
    chk("t4_armed_after_second", int'(armed[0]), 0);
    chk("t4_sb_drained", sb_q.size(), 0);

    // Test 5: continuous toggling, disable during a high cycle.
    cfg_oneshot[0] = 1'b0; cfg_edge[1:0] = 2'b11; cfg_delay[0 +: CW] = 16'd0;
    cfg_width[0 +: CW] = 16'd1; cfg_gap[0 +: CW] = 16'd1; cfg_repeat[0 +: 8] = 8'd0;
    @(negedge clk);
    chk("t5_armed", int'(armed[0]), 1);
    sw_start[0] = 1'b1; t = cyc + 1;
    for (int k = 1; k <= 10; k++) push(t + k, 0, (k % 2 == 1) ? K_RISE : K_FALL);
    @(negedge clk); sw_start[0] = 1'b0;
    wait_idx(t + 9);
    chk("t5_pulse_high", int'(pulse[0]), 1);
    cfg_en[0] = 1'b0;
    @(negedge clk);
    chk("t5_dis_pulse", int'(pulse[0]), 0);
    chk("t5_dis_busy", int'(busy[0]), 0);
    cfg_en[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_sb_drained", sb_q.size(), 0);

    // Test 6: reset in the middle of a high phase, then restart.
    cfg_delay[0 +: CW] = 16'd2; cfg_width[0 +: CW] = 16'd5;
    cfg_gap[0 +: CW] = 16'd1; cfg_repeat[0 +: 8] = 8'd2;
    @(negedge clk);
    sw_start[0] = 1'b1; t = cyc + 1;
    push(t + 3, 0, K_RISE); push(t + 5, 0, K_FALL);
    @(negedge clk); sw_start[0] = 1'b0;
    @(negedge clk); sw_start[0] = 1'b1;
    @(negedge clk); sw_start[0] = 1'b0;
    @(negedge clk);
    chk("t6_missed_pre", int'(missed[7:0]), 1);
    chk("t6_pulse_pre", int'(pulse[0]), 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset_values("t6_reset");
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    sw_start[0] = 1'b1; t2 = cyc + 1;
    push(t2 + 3, 0, K_RISE);  push(t2 + 8, 0, K_FALL);
    push(t2 + 9, 0, K_RISE);  push(t2 + 14, 0, K_FALL); push(t2 + 14, 0, K_DONE);
    @(negedge clk); sw_start[0] = 1'b0;
    wait_idx(t2 + 16);
    chk("t6_busy_end", int'(busy[0]), 0);
    chk("t6_sb_drained", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/multi_sync_pulser.md
# multi_sync_pulser

Parametrised multi-channel pulse sequencer for the probe-card FPGA. Each channel synchronises one asynchronous DUT sync input (R2S, FSYNC, ...), detects a selectable edge, and emits a delayed, programmable pulse train. The pulse trains serve as start strobes for the sequence generator and sequence recorder. Adds per-channel edge selection, repeat/continuous bursts, one-shot arming and missed-trigger counting.

## Interface
Parameters:
- CHANNELS, 2, number of independent channels (1..16)
- CNT_WIDTH, 16, width of delay/width/gap counters
- SYNC_STAGES, 2, synchroniser flops per SYNC_IN bit (>=2)

Ports (channel i occupies slice [i*W +: W] of packed vectors):
- CLK  in  1  single clock for all logic
- RST_N  in  1  synchronous, active-low reset
- SYNC_IN  in  CHANNELS  asynchronous sync inputs
- SW_START  in  CHANNELS  software trigger, CLK domain, one-cycle pulse
- ARM  in  CHANNELS  re-arm pulse for one-shot channels
- CLEAR  in  CHANNELS  clears MISSED counter
- CFG_EN  in  CHANNELS  channel enable
- CFG_EDGE  in  2*CHANNELS  00 rising, 01 falling, 10 both, 11 none (SW_START only)
- CFG_ONESHOT  in  CHANNELS  1 = disarm after each completed train
- CFG_DELAY  in  CNT_WIDTH*CHANNELS  cycles from trigger to first pulse
- CFG_WIDTH  in  CNT_WIDTH*CHANNELS  pulse high time in cycles (0 treated as 1)
- CFG_GAP  in  CNT_WIDTH*CHANNELS  low time between pulses (0 treated as 1)
- CFG_REPEAT  in  8*CHANNELS  pulses per train; 0 = continuous
- STROBE  out  CHANNELS  one-cycle detected-edge strobe (before CFG_EN gating)
- PULSE  out  CHANNELS  registered pulse output
- BUSY  out  CHANNELS  channel not IDLE
- DONE  out  CHANNELS  one-cycle strobe at train completion
- ARMED  out  CHANNELS  channel accepts triggers
- MISSED  out  8*CHANNELS  saturating count of triggers rejected while BUSY

## Operation
- Sync path: SYNC_IN -> SYNC_STAGES flops -> one history flop; STROBE derived from last stage vs history per CFG_EDGE.
- Trigger = (STROBE | SW_START) & CFG_EN & ARMED; simultaneous STROBE and SW_START = one trigger.
- On accepted trigger in IDLE: latch DELAY, WIDTH, GAP, REPEAT into channel shadow registers; later CFG changes do not affect the running train.
- FSM per channel: IDLE -> DELAY (skipped if DELAY=0) -> HIGH -> GAP -> HIGH ... -> IDLE.
- HIGH: PULSE=1 for WIDTH cycles; on exit, pulse counter incremented; if REPEAT!=0 and count==REPEAT -> IDLE with DONE, else -> GAP.
- GAP: PULSE=0 for GAP cycles, then HIGH. No trailing gap after last pulse.
- REPEAT=0: repeats until CFG_EN deasserted; never asserts DONE.
- Trigger while BUSY and CFG_EN=1: ignored, MISSED += 1, saturating at 255. Triggers while disarmed ignored and not counted.
- CFG_ONESHOT=1: ARMED cleared in the cycle DONE asserts; ARM pulse sets it. ARM while BUSY sets ARMED. CFG_ONESHOT=0: ARMED stays 1.
- CFG_EN deasserted in any state: next edge -> IDLE, PULSE=0, no DONE, pulse counter cleared.
- CLEAR and a counted miss in same cycle: CLEAR wins (MISSED=0).

## Timing
- Reset (RST_N low at an edge): all FSMs IDLE; STROBE, PULSE, BUSY, DONE, MISSED = 0; ARMED = all 1; synchroniser and history flops = 0.
- SYNC_IN edge captured at CLK edge k: STROBE high for exactly one cycle, sampled at edge k+SYNC_STAGES.
- Trigger sampled at edge T: BUSY=1 from T+1; first PULSE high sampled at edge T+1+DELAY.
- DONE high for one cycle, together with the first cycle after the last PULSE low; BUSY falls in that same cycle.
- A new trigger is accepted in the cycle after DONE; the return to IDLE costs no dead cycle.
- All outputs registered except STROBE (decoded from registered sync/history flops).

## Test plan
- Rising edge, CHANNELS=2, ch0 DELAY=3 WIDTH=2 GAP=4 REPEAT=3: SYNC_IN[0] rises -> STROBE at k+2, PULSE high at T+4..T+5, T+10..T+11, T+16..T+17, DONE at T+18, MISSED=0.
- CFG_EDGE=10 with a 40-cycle SYNC_IN pulse, DELAY=0 WIDTH=1 REPEAT=1: two trains, each with PULSE high at T+1 and DONE at T+2.
- Retrigger during a train, 300 triggers while BUSY: MISSED saturates at 255; CLEAR -> 0 next cycle.
- One-shot: CFG_ONESHOT=1, trigger -> DONE, ARMED=0; second edge gives no PULSE and MISSED unchanged; ARM pulse, third edge -> normal train.
- REPEAT=0 WIDTH=1 GAP=1: PULSE toggles every cycle; CFG_EN low -> PULSE=0 and BUSY=0 next edge, no DONE.
- RST_N low mid-HIGH with CFG held: next edge all outputs at reset values; SW_START after release -> train restarts with DELAY honoured.
